shift_add_multiplier: RTL

Sequential unsigned N×N multiplier built around the team's N-bit ripple-carry adder, which it drives every cycle with the running partial product and the multiplicand. It accepts operands with a single-cycle start handshake and performs one shift-and-add iteration per clock. It returns a 2N-bit product with a one-cycle done pulse. Intended as the first multi-cycle consumer of the adder in the building-blocks library, trading area for latency.

---
 rtl/shift_add_multiplier_pkg.sv | 16 +
 rtl/shift_add_multiplier_if.sv | 24 ++
 rtl/shift_add_multiplier_rca.sv | 23 ++
 rtl/shift_add_multiplier.sv | 130 +++++++++++++
 4 files changed

// File: rtl/shift_add_multiplier_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
// Holds the FSM state encoding and the iteration-counter width helper.
package shift_add_multiplier_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Width of the iteration counter; it must hold values up to n-1.
  function automatic int unsigned count_width(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage : shift_add_multiplier_pkg

// File: rtl/shift_add_multiplier_if.sv
// Start/result handshake bundle between a requester and the multiplier.
interface shift_add_multiplier_if #(
  parameter int unsigned N = 8
) ();

  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           ready;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  modport master (
    output start, a, b,
    input  ready, busy, done, product
  );

  modport slave (
    input  start, a, b,
    output ready, busy, done, product
  );

endinterface : shift_add_multiplier_if

// File: rtl/shift_add_multiplier_rca.sv
// N-bit ripple-carry adder; o_overflow is the unsigned carry out of the MSB.
module shift_add_multiplier_rca #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_cin,
  output logic [N-1:0] o_sum,
  output logic         o_overflow
);

  logic [N:0] w_carry;

  assign w_carry[0] = i_cin;

  for (genvar g = 0; g < N; g++) begin : g_fa
    assign o_sum[g]       = i_a[g] ^ i_b[g] ^ w_carry[g];
    assign w_carry[g + 1] = (i_a[g] & i_b[g]) | (w_carry[g] & (i_a[g] ^ i_b[g]));
  end

  assign o_overflow = w_carry[N];

endmodule : shift_add_multiplier_rca

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned NxN multiplier: one shift-and-add iteration per clock,
// N iterations per operation, 2N-bit product with a one-cycle done pulse.
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  shift_add_multiplier_if.slave  s_mul
);

  localparam int unsigned CW = count_width(N);
  localparam int unsigned PW = 2 * N;

  state_e          r_state;
  state_e          w_state_nxt;
  logic            w_accept;
  logic            w_last;
  logic            w_ready_nxt;
  logic            w_busy_nxt;
  logic            w_done_nxt;

  logic            r_ready;
  logic            r_busy;
  logic            r_done;
  logic [CW-1:0]   r_count;
  logic [N-1:0]    r_acc;
  logic [N-1:0]    r_mq;
  logic [N-1:0]    r_mcand;
  logic [PW-1:0]   r_product;

  logic [N-1:0]    w_add_b;
  logic [N-1:0]    w_sum;
  logic            w_cout;
  logic [N-1:0]    w_acc_nxt;
  logic [N-1:0]    w_mq_nxt;

  // Multiplicand is added only when the current multiplier LSB is set.
  assign w_add_b = r_mq[0] ? r_mcand : '0;

  shift_add_multiplier_rca #(
    .N (N)
  ) u_rca (
    .i_a        (r_acc),
    .i_b        (w_add_b),
    .i_cin      (1'b0),
    .o_sum      (w_sum),
    .o_overflow (w_cout)
  );

  // {acc, mq} <= {cout, sum, mq} >> 1
  assign w_acc_nxt = {w_cout, w_sum[N-1:1]};
  assign w_mq_nxt  = {w_sum[0], r_mq[N-1:1]};

  // Next-state decode; status flags are derived from the next state so they
  // can be registered alongside it.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (s_mul.start) begin
          w_state_nxt = ST_RUN;
          w_accept    = 1'b1;
        end
      end
      ST_RUN: begin
        if (r_count == CW'(N - 1)) begin
          w_state_nxt = ST_DONE;
          w_last      = 1'b1;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    w_ready_nxt = (w_state_nxt == ST_IDLE);
    w_busy_nxt  = (w_state_nxt == ST_RUN);
    w_done_nxt  = (w_state_nxt == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= w_ready_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Datapath: load on accept, iterate while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_mq    <= '0;
      r_mcand <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      r_acc   <= '0;
      r_mq    <= s_mul.b;
      r_mcand <= s_mul.a;
      r_count <= '0;
    end else if (r_state == ST_RUN) begin
      r_acc   <= w_acc_nxt;
      r_mq    <= w_mq_nxt;
      r_count <= r_count + CW'(1);
    end
  end

  // Product only changes on the final iteration's edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_product <= '0;
    end else if (w_last) begin
      r_product <= {w_acc_nxt, w_mq_nxt};
    end
  end

  assign s_mul.ready   = r_ready;
  assign s_mul.busy    = r_busy;
  assign s_mul.done    = r_done;
  assign s_mul.product = r_product;

endmodule : shift_add_multiplier
